// File: rtl/banco_nos_ativos.sv
// Active-node register bank: slot write/deactivate driven by the node manager,
// plus a sequential minimum-cost scan over the active slots.
module banco_nos_ativos #(
  parameter int NUM_NA          = 8,
  parameter int ADR_WIDTH       = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  localparam int CUSTO_TOTAL_WIDTH = DISTANCIA_WIDTH + 1,
  localparam int IDX_WIDTH         = $clog2(NUM_NA)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ga_desativar_in,
  input  logic                           ga_atualizar_in,
  input  logic [ADR_WIDTH-1:0]           ga_endereco_in,
  input  logic [ADR_WIDTH-1:0]           ga_anterior_in,
  input  logic [CUSTO_WIDTH-1:0]         ga_menor_vizinho_in,
  input  logic [DISTANCIA_WIDTH-1:0]     ga_distancia_in,
  input  logic [NUM_NA-1:0]              ga_habilitar_in,
  input  logic                           menor_req_in,
  output logic [ADR_WIDTH*NUM_NA-1:0]    na_endereco_out,
  output logic [NUM_NA-1:0]              na_ativo_out,
  output logic                           ba_menor_valido_out,
  output logic                           ba_menor_encontrado_out,
  output logic [IDX_WIDTH-1:0]           ba_menor_idx_out,
  output logic [ADR_WIDTH-1:0]           ba_menor_endereco_out,
  output logic [ADR_WIDTH-1:0]           ba_menor_anterior_out,
  output logic [DISTANCIA_WIDTH-1:0]     ba_menor_distancia_out,
  output logic                           ba_erro_o,
  output logic                           ba_ocupado_o,
  output logic                           ba_cheio_o,
  output logic                           ba_vazio_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSCA, ST_RESULTADO} estado_t;

  estado_t state, state_next;

  logic [ADR_WIDTH-1:0]         endereco  [NUM_NA];
  logic [ADR_WIDTH-1:0]         anterior  [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0]   distancia [NUM_NA];
  logic [CUSTO_TOTAL_WIDTH-1:0] custo     [NUM_NA];
  logic [NUM_NA-1:0]            ativo;

  logic [IDX_WIDTH-1:0]         sel_idx;
  logic                         sel_hit;
  logic                         multi_hot;
  logic [CUSTO_TOTAL_WIDTH-1:0] custo_novo;

  logic [IDX_WIDTH-1:0]         scan_idx;
  logic                         best_ok;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic [CUSTO_TOTAL_WIDTH-1:0] best_custo;
  logic [ADR_WIDTH-1:0]         best_endereco;
  logic [ADR_WIDTH-1:0]         best_anterior;
  logic [DISTANCIA_WIDTH-1:0]   best_distancia;

  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (ga_habilitar_in[i] && !sel_hit) begin
        sel_idx = IDX_WIDTH'(i);
        sel_hit = 1'b1;
      end
    end
  end

  assign multi_hot  = (ga_habilitar_in & (ga_habilitar_in - NUM_NA'(1))) != '0;
  assign custo_novo = CUSTO_TOTAL_WIDTH'(ga_distancia_in) + CUSTO_TOTAL_WIDTH'(ga_menor_vizinho_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_NA; i++) begin
        endereco[i]  <= '0;
        anterior[i]  <= '0;
        distancia[i] <= '0;
        custo[i]     <= '0;
      end
      ativo     <= '0;
      ba_erro_o <= 1'b0;
    end else begin
      if (multi_hot) ba_erro_o <= 1'b1;
      if (sel_hit) begin
        if (ga_desativar_in) begin
          ativo[sel_idx] <= 1'b0;
        end else if (ga_atualizar_in) begin
          if (!ativo[sel_idx]) begin
            endereco[sel_idx]  <= ga_endereco_in;
            anterior[sel_idx]  <= ga_anterior_in;
            distancia[sel_idx] <= ga_distancia_in;
            custo[sel_idx]     <= custo_novo;
            ativo[sel_idx]     <= 1'b1;
          end else if (endereco[sel_idx] == ga_endereco_in && custo_novo < custo[sel_idx]) begin
            anterior[sel_idx]  <= ga_anterior_in;
            distancia[sel_idx] <= ga_distancia_in;
            custo[sel_idx]     <= custo_novo;
          end
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (menor_req_in) state_next = ST_BUSCA;
      ST_BUSCA:     if (scan_idx == IDX_WIDTH'(NUM_NA - 1)) state_next = ST_RESULTADO;
      ST_RESULTADO: state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Winner fields are captured at scan time so later writes to that slot
  // cannot alter a result already chosen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_IDLE;
      scan_idx                <= '0;
      best_ok                 <= 1'b0;
      best_idx                <= '0;
      best_custo              <= '0;
      best_endereco           <= '0;
      best_anterior           <= '0;
      best_distancia          <= '0;
      ba_menor_valido_out     <= 1'b0;
      ba_menor_encontrado_out <= 1'b0;
      ba_menor_idx_out        <= '0;
      ba_menor_endereco_out   <= '0;
      ba_menor_anterior_out   <= '0;
      ba_menor_distancia_out  <= '0;
    end else begin
      state               <= state_next;
      ba_menor_valido_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (menor_req_in) begin
            scan_idx <= '0;
            best_ok  <= 1'b0;
          end
        end
        ST_BUSCA: begin
          if (ativo[scan_idx] && (!best_ok || custo[scan_idx] < best_custo)) begin
            best_ok        <= 1'b1;
            best_idx       <= scan_idx;
            best_custo     <= custo[scan_idx];
            best_endereco  <= endereco[scan_idx];
            best_anterior  <= anterior[scan_idx];
            best_distancia <= distancia[scan_idx];
          end
          scan_idx <= scan_idx + IDX_WIDTH'(1);
        end
        ST_RESULTADO: begin
          ba_menor_valido_out     <= 1'b1;
          ba_menor_encontrado_out <= best_ok;
          ba_menor_idx_out        <= best_ok ? best_idx       : '0;
          ba_menor_endereco_out   <= best_ok ? best_endereco  : '0;
          ba_menor_anterior_out   <= best_ok ? best_anterior  : '0;
          ba_menor_distancia_out  <= best_ok ? best_distancia : '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    na_endereco_out = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      na_endereco_out[ADR_WIDTH*i +: ADR_WIDTH] = endereco[i];
    end
  end

  assign na_ativo_out = ativo;
  assign ba_ocupado_o = (state != ST_IDLE);
  assign ba_cheio_o   = &ativo;
  assign ba_vazio_o   = ~|ativo;

endmodule

// File: tb/tb_banco_nos_ativos.sv
// Scoreboarded bench for banco_nos_ativos: directed writes and searches, with
// expected search results queued and checked by an independent strobe monitor.
module tb_banco_nos_ativos;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        desativar = 1'b0;
  logic        atualizar = 1'b0;
  logic [4:0]  endereco = '0;
  logic [4:0]  anterior = '0;
  logic [3:0]  vizinho = '0;
  logic [4:0]  distancia = '0;
  logic [7:0]  habilitar = '0;
  logic        req = 1'b0;
  logic [39:0] na_endereco;
  logic [7:0]  na_ativo;
  logic        valido, encontrado;
  logic [2:0]  idx;
  logic [4:0]  m_endereco, m_anterior, m_distancia;
  logic        erro, ocupado, cheio, vazio;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic       enc;
    logic [2:0] idx;
    logic [4:0] endereco;
    logic [4:0] anterior;
    logic [4:0] distancia;
    int         cyc;
  } exp_t;
  exp_t fila[$];

  banco_nos_ativos #(
    .NUM_NA(8),
    .ADR_WIDTH(5),
    .DISTANCIA_WIDTH(5),
    .CUSTO_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ga_desativar_in(desativar),
    .ga_atualizar_in(atualizar),
    .ga_endereco_in(endereco),
    .ga_anterior_in(anterior),
    .ga_menor_vizinho_in(vizinho),
    .ga_distancia_in(distancia),
    .ga_habilitar_in(habilitar),
    .menor_req_in(req),
    .na_endereco_out(na_endereco),
    .na_ativo_out(na_ativo),
    .ba_menor_valido_out(valido),
    .ba_menor_encontrado_out(encontrado),
    .ba_menor_idx_out(idx),
    .ba_menor_endereco_out(m_endereco),
    .ba_menor_anterior_out(m_anterior),
    .ba_menor_distancia_out(m_distancia),
    .ba_erro_o(erro),
    .ba_ocupado_o(ocupado),
    .ba_cheio_o(cheio),
    .ba_vazio_o(vazio)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valido === 1'b1) begin
      if (fila.size() == 0) begin
        chk("strobe_inesperado", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = fila.pop_front();
        chk("strobe_ciclo",  64'(cyc), 64'(e.cyc));
        chk("encontrado",    64'(encontrado), 64'(e.enc));
        chk("menor_idx",     64'(idx), 64'(e.idx));
        chk("menor_end",     64'(m_endereco), 64'(e.endereco));
        chk("menor_ant",     64'(m_anterior), 64'(e.anterior));
        chk("menor_dist",    64'(m_distancia), 64'(e.distancia));
      end
    end
  end

  task automatic wr(input logic d, input logic a, input logic [7:0] h, input logic [4:0] e,
                    input logic [4:0] an, input logic [4:0] di, input logic [3:0] v);
    @(negedge clk);
    desativar = d; atualizar = a; habilitar = h;
    endereco = e; anterior = an; distancia = di; vizinho = v;
    @(posedge clk);
    #1;
    habilitar = '0; desativar = 1'b0; atualizar = 1'b0;
  endtask

  task automatic busca(input logic enc, input logic [2:0] i, input logic [4:0] e,
                       input logic [4:0] an, input logic [4:0] di);
    int n;
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    fila.push_back('{enc, i, e, an, di, cyc + 9});
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ocupado) n++;
    end
    chk("ocupado_ciclos", 64'(n), 64'd9);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_vazio", 64'(vazio), 64'd1);
    chk("reset_cheio", 64'(cheio), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ativo", 64'(na_ativo), 64'h00);
    chk("idle_vazio", 64'(vazio), 64'd1);
    chk("idle_cheio", 64'(cheio), 64'd0);
    chk("idle_res", {valido, encontrado, idx, m_endereco, m_anterior, m_distancia, erro, ocupado}, 64'd0);

    wr(0, 1, 8'h04, 5'd9, 5'd3, 5'd7, 4'd2);
    @(negedge clk);
    chk("ins_ativo", 64'(na_ativo), 64'h04);
    chk("ins_end", 64'(na_endereco[14:10]), 64'd9);

    wr(0, 1, 8'h04, 5'd9, 5'd11, 5'd4, 4'd1);   // custo 5 < 9: update
    wr(0, 1, 8'h04, 5'd9, 5'd20, 5'd6, 4'd3);   // custo 9 > 5: ignored
    wr(0, 1, 8'h04, 5'd10, 5'd1, 5'd0, 4'd0);   // address mismatch: ignored
    @(negedge clk);
    chk("upd_ativo", 64'(na_ativo), 64'h04);
    chk("upd_end", 64'(na_endereco[14:10]), 64'd9);
    busca(1, 3'd2, 5'd9, 5'd11, 5'd4);

    wr(1, 0, 8'h04, 5'd0, 5'd0, 5'd0, 4'd0);
    wr(0, 1, 8'h02, 5'd1, 5'd2, 5'd10, 4'd2);   // custo 12
    wr(0, 1, 8'h20, 5'd5, 5'd7, 5'd3, 4'd2);    // custo 5
    wr(0, 1, 8'h40, 5'd6, 5'd8, 5'd5, 4'd0);    // custo 5, loses tie
    @(negedge clk);
    chk("tres_ativo", 64'(na_ativo), 64'h62);
    chk("tres_erro", 64'(erro), 64'd0);
    busca(1, 3'd5, 5'd5, 5'd7, 5'd3);

    wr(1, 1, 8'h20, 5'd5, 5'd7, 5'd0, 4'd0);
    @(negedge clk);
    chk("desat_ativo", 64'(na_ativo), 64'h42);
    wr(0, 1, 8'h06, 5'd1, 5'd9, 5'd0, 4'd0);
    @(negedge clk);
    chk("multi_ativo", 64'(na_ativo), 64'h42);
    chk("multi_erro", 64'(erro), 64'd1);
    busca(1, 3'd1, 5'd1, 5'd9, 5'd0);

    wr(1, 0, 8'h02, 5'd0, 5'd0, 5'd0, 4'd0);
    wr(1, 0, 8'h40, 5'd0, 5'd0, 5'd0, 4'd0);
    @(negedge clk);
    chk("vazio_ativo", 64'(na_ativo), 64'h00);
    chk("vazio_flag", 64'(vazio), 64'd1);
    busca(0, 3'd0, 5'd0, 5'd0, 5'd0);

    wr(0, 1, 8'h80, 5'd31, 5'd4, 5'd31, 4'd15);  // custo 46, no overflow
    wr(0, 1, 8'h01, 5'd3, 5'd5, 5'd31, 4'd15);   // custo 46
    wr(0, 1, 8'h80, 5'd31, 5'd6, 5'd31, 4'd14);  // custo 45: update
    busca(1, 3'd7, 5'd31, 5'd6, 5'd31);

    for (int k = 1; k < 7; k++) begin
      wr(0, 1, 8'(1 << k), 5'(k), 5'd0, 5'd31, 4'd15);
    end
    @(negedge clk);
    chk("cheio_ativo", 64'(na_ativo), 64'hff);
    chk("cheio_flag", 64'(cheio), 64'd1);
    chk("cheio_vazio", 64'(vazio), 64'd0);

    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ativo", 64'(na_ativo), 64'h00);
    chk("rst_ocupado", 64'(ocupado), 64'd0);
    chk("rst_vazio", 64'(vazio), 64'd1);
    chk("rst_erro", 64'(erro), 64'd0);
    chk("rst_end", 64'(na_endereco), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("fila_vazia", 64'(fila.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
